// File: rtl/hash_msg_feeder.sv
// Buffers one host message, replays it to the hash core as a byte burst,
// then waits for the core's digest and returns it with a one-cycle strobe.
module hash_msg_feeder #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  input  logic        in_last,
  output logic        in_ready,
  output logic        M_valid,
  output logic [7:0]  message,
  output logic [63:0] counter,
  input  logic        hash_ready,
  input  logic [31:0] digest_in,
  output logic [31:0] digest_out,
  output logic        digest_valid,
  output logic        busy,
  output logic        err_overflow,
  output logic        err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DROP    = 2'd1,
    FEED    = 2'd2,
    WAIT    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            hash_ready_p0;
  logic            hr_rise;
  logic            accept;
  logic            wr_en;

  logic            in_ready_d, M_valid_d, digest_valid_d, busy_d;
  logic            err_overflow_d, err_timeout_d;
  logic [7:0]      message_d;
  logic [63:0]     counter_d;
  logic [31:0]     digest_out_d;

  logic [7:0]      mem [DEPTH];

  assign accept  = in_valid & in_ready;
  // Rise is live level against last registered sample, so a level already
  // high when WAIT is entered never looks like a new digest.
  assign hr_rise = hash_ready & ~hash_ready_p0;

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    rd_ptr_d       = rd_ptr_q;
    tcnt_d         = tcnt_q;
    wr_en          = 1'b0;
    M_valid_d      = 1'b0;
    message_d      = 8'h00;
    counter_d      = 64'd0;
    digest_out_d   = digest_out;
    digest_valid_d = 1'b0;
    err_overflow_d = 1'b0;
    err_timeout_d  = 1'b0;

    case (state_q)
      COLLECT: begin
        if (accept) begin
          wr_en = 1'b1;
          len_d = len_q + LW'(1);
          if (in_last) begin
            state_d  = FEED;
            rd_ptr_d = '0;
          end else if (len_q == LW'(DEPTH - 1)) begin
            state_d        = DROP;
            err_overflow_d = 1'b1;
            len_d          = '0;
          end
        end
      end
      DROP: begin
        if (accept && in_last) state_d = COLLECT;
      end
      FEED: begin
        M_valid_d = 1'b1;
        message_d = mem[rd_ptr_q[AW-1:0]];
        counter_d = {{(64 - LW){1'b0}}, len_q};
        rd_ptr_d  = rd_ptr_q + LW'(1);
        if (rd_ptr_q == len_q - LW'(1)) begin
          state_d = WAIT;
          tcnt_d  = '0;
        end
      end
      WAIT: begin
        tcnt_d = tcnt_q + TW'(1);
        // A digest arriving on the expiry edge still wins over the timeout.
        if (hr_rise) begin
          digest_out_d   = digest_in;
          digest_valid_d = 1'b1;
          len_d          = '0;
          tcnt_d         = '0;
          state_d        = COLLECT;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          err_timeout_d = 1'b1;
          len_d         = '0;
          tcnt_d        = '0;
          state_d       = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase

    in_ready_d = (state_d == COLLECT) || (state_d == DROP);
    busy_d     = (state_d == FEED) || (state_d == WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= COLLECT;
      len_q         <= '0;
      rd_ptr_q      <= '0;
      tcnt_q        <= '0;
      hash_ready_p0 <= 1'b0;
      in_ready      <= 1'b1;
      M_valid       <= 1'b0;
      message       <= 8'h00;
      counter       <= 64'd0;
      digest_out    <= 32'd0;
      digest_valid  <= 1'b0;
      busy          <= 1'b0;
      err_overflow  <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      rd_ptr_q      <= rd_ptr_d;
      tcnt_q        <= tcnt_d;
      hash_ready_p0 <= hash_ready;
      in_ready      <= in_ready_d;
      M_valid       <= M_valid_d;
      message       <= message_d;
      counter       <= counter_d;
      digest_out    <= digest_out_d;
      digest_valid  <= digest_valid_d;
      busy          <= busy_d;
      err_overflow  <= err_overflow_d;
      err_timeout   <= err_timeout_d;
    end
  end

  // Message storage carries no reset; stale bytes are never read past len.
  always_ff @(posedge clk) begin
    if (wr_en) mem[len_q[AW-1:0]] <= in_byte;
  end

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Bench for hash_msg_feeder: table vectors, hand sequences and random messages
// compared against a message-level reference model.
module tb_hash_msg_feeder;

  localparam int DEPTH   = 16;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_last;
  logic        in_ready;
  logic        M_valid;
  logic [7:0]  message;
  logic [63:0] counter;
  logic        hash_ready;
  logic [31:0] digest_in;
  logic [31:0] digest_out;
  logic        digest_valid;
  logic        busy;
  logic        err_overflow;
  logic        err_timeout;

  hash_msg_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_byte(in_byte), .in_last(in_last), .in_ready(in_ready),
    .M_valid(M_valid), .message(message), .counter(counter),
    .hash_ready(hash_ready), .digest_in(digest_in),
    .digest_out(digest_out), .digest_valid(digest_valid), .busy(busy),
    .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0]  msg_q[$];
  logic [31:0] last_dig = 32'd0;
  bit          junk_en = 1'b0;
  bit          gaps_en = 1'b0;

  typedef struct {
    int          len;
    logic [7:0]  seed;
    int          n;
    bit          pre_high;
    logic [31:0] dig;
    bit          exp_fed;
    bit          exp_ok;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive_junk();
    if (junk_en) begin
      in_valid = 1'($urandom);
      in_byte  = 8'($urandom);
      in_last  = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  // Sends msg_q; a message longer than DEPTH must overflow on its DEPTH-th byte.
  task automatic send_msg();
    int L = msg_q.size();
    for (int i = 0; i < L; i++) begin
      if (gaps_en) begin
        int g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          in_valid = 1'b0;
          in_byte  = 8'($urandom);
          in_last  = 1'b0;
          cyc();
        end
      end
      chk("in_ready_collect", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_byte  = msg_q[i];
      in_last  = (i == L - 1);
      cyc();
      chk("err_overflow", 64'(err_overflow), 64'((L > DEPTH) && (i == DEPTH - 1)));
      chk("no_mvalid_collect", 64'(M_valid), 64'd0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_feed();
    int L = msg_q.size();
    chk("feed_inready0", 64'(in_ready), 64'd0);
    chk("feed_busy_start", 64'(busy), 64'd1);
    chk("feed_mvalid_lat", 64'(M_valid), 64'd0);
    drive_junk();
    for (int i = 0; i < L; i++) begin
      cyc();
      chk("feed_mvalid", 64'(M_valid), 64'd1);
      chk("feed_message", 64'(message), 64'(msg_q[i]));
      chk("feed_counter", counter, 64'(L));
      chk("feed_busy", 64'(busy), 64'd1);
      chk("feed_inready", 64'(in_ready), 64'd0);
      drive_junk();
    end
  endtask

  // WAIT cycle 1 is the cycle showing the last M_valid byte. A rise driven
  // in WAIT cycle n is seen on the edge ending cycle n.
  task automatic run_wait(input int n, input logic [31:0] val, input bit pre_high, input bit ok);
    int end_c = ok ? n : TIMEOUT;
    for (int c = 1; c <= end_c + 2; c++) begin
      if (c > 1) begin
        chk("wait_mvalid", 64'(M_valid), 64'd0);
        chk("wait_message", 64'(message), 64'd0);
        chk("wait_counter", counter, 64'd0);
      end
      chk("wait_busy", 64'(busy), 64'(c <= end_c));
      chk("wait_inready", 64'(in_ready), 64'(c > end_c));
      chk("digest_valid", 64'(digest_valid), 64'(ok && (c == end_c + 1)));
      chk("err_timeout", 64'(err_timeout), 64'(!ok && (c == end_c + 1)));
      if (c <= end_c) drive_junk();
      else in_valid = 1'b0;
      if (!pre_high && c == n) begin
        hash_ready = 1'b1;
        digest_in  = val;
      end
      cyc();
    end
    if (ok) last_dig = val;
    chk("digest_out", 64'(digest_out), 64'(last_dig));
    in_valid   = 1'b0;
    hash_ready = 1'b0;
    cyc();
  endtask

  task automatic run_msg(input int n, input logic [31:0] val, input bit pre_high,
                         input bit fed, input bit ok);
    if (pre_high) begin
      hash_ready = 1'b1;
      digest_in  = val;
    end
    send_msg();
    if (fed) begin
      check_feed();
      run_wait(n, val, pre_high, ok);
    end else begin
      cyc();
      chk("drop_inready", 64'(in_ready), 64'd1);
      chk("drop_busy", 64'(busy), 64'd0);
      chk("drop_mvalid", 64'(M_valid), 64'd0);
      hash_ready = 1'b0;
    end
  endtask

  initial begin
    tbl[0] = '{1,  8'h41, 3,  1'b0, 32'h4dd99065, 1'b1, 1'b1};
    tbl[1] = '{3,  8'h41, 5,  1'b0, 32'h12345678, 1'b1, 1'b1};
    tbl[2] = '{16, 8'h60, 10, 1'b0, 32'hcafef00d, 1'b1, 1'b1};
    tbl[3] = '{19, 8'h70, 0,  1'b0, 32'h00000000, 1'b0, 1'b0};
    tbl[4] = '{1,  8'h5a, 2,  1'b0, 32'h0badc0de, 1'b1, 1'b1};
    tbl[5] = '{4,  8'h10, 0,  1'b1, 32'hdeadbeef, 1'b1, 1'b0};
    tbl[6] = '{2,  8'h20, 64, 1'b0, 32'ha5a5a5a5, 1'b1, 1'b1};
    tbl[7] = '{2,  8'h21, 65, 1'b0, 32'h5a5a5a5a, 1'b1, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_byte = 8'h00; in_last = 1'b0;
    hash_ready = 1'b0; digest_in = 32'd0;
    cyc(); cyc();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mvalid", 64'(M_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_digest_out", 64'(digest_out), 64'd0);
    chk("rst_digest_valid", 64'(digest_valid), 64'd0);
    chk("rst_errs", 64'({err_overflow, err_timeout}), 64'd0);
    rst_n = 1'b1;
    cyc();

    foreach (tbl[t]) begin
      msg_q.delete();
      for (int i = 0; i < tbl[t].len; i++) msg_q.push_back(8'(tbl[t].seed + 8'(i)));
      run_msg(tbl[t].n, tbl[t].dig, tbl[t].pre_high, tbl[t].exp_fed, tbl[t].exp_ok);
    end

    // Reset in the middle of a burst, then the next message starts at byte 0.
    msg_q.delete();
    for (int i = 0; i < 5; i++) msg_q.push_back(8'(8'h30 + 8'(i)));
    send_msg();
    cyc(); cyc();
    chk("pre_rst_mvalid", 64'(M_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_mvalid", 64'(M_valid), 64'd0);
    chk("async_rst_inready", 64'(in_ready), 64'd1);
    cyc();
    rst_n = 1'b1;
    last_dig = 32'd0;
    cyc();
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_digest_valid", 64'(digest_valid), 64'd0);
    chk("post_rst_mvalid", 64'(M_valid), 64'd0);
    msg_q.delete();
    msg_q.push_back(8'h5a);
    run_msg(4, 32'h01020304, 1'b0, 1'b1, 1'b1);

    // Random messages against the message-level model.
    gaps_en = 1'b1;
    junk_en = 1'b1;
    for (int r = 0; r < 40; r++) begin
      int L   = $urandom_range(1, 22);
      int n   = $urandom_range(1, 70);
      bit pre = ($urandom_range(0, 9) == 0);
      logic [31:0] d = $urandom;
      msg_q.delete();
      for (int i = 0; i < L; i++) msg_q.push_back(8'($urandom));
      run_msg(n, d, pre, (L <= DEPTH), (!pre && n <= TIMEOUT));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hash_msg_feeder.md
# hash_msg_feeder

Front-end controller that sits directly upstream of `full_hash_des_box`. It collects a complete byte message from a host byte stream into a local buffer, then replays the message to the hash core as a burst of `M_valid` bytes with the message length on `counter`. It then waits for the core's `hash_ready` and returns the 32-bit digest to the host with a one-cycle valid strobe. Overflow and core-timeout conditions are reported as error pulses.

## Interface
- `DEPTH`, 16 — message buffer capacity in bytes; power of 2, at least 2; maximum message length.
- `TIMEOUT`, 64 — maximum cycles spent in WAIT before `err_timeout`.
- `clk` in 1 — system clock; all state is updated on the rising edge.
- `rst_n` in 1 — reset, asynchronous and active-low.
- `in_valid` in 1 — host byte valid.
- `in_byte` in 8 — host message byte.
- `in_last` in 1 — marks the final byte of a message; qualified by `in_valid`.
- `in_ready` out 1 — feeder can accept a byte; a byte is transferred on an edge where `in_valid & in_ready`.
- `M_valid` out 1 — byte strobe to the hash core.
- `message` out 8 — byte to the hash core.
- `counter` out 64 — message length in bytes, zero-extended; to the hash core.
- `hash_ready` in 1 — digest-valid level from the hash core.
- `digest_in` in 32 — digest from the hash core.
- `digest_out` out 32 — last captured digest.
- `digest_valid` out 1 — one-cycle pulse when `digest_out` is updated.
- `busy` out 1 — high in FEED and WAIT.
- `err_overflow` out 1 — one-cycle pulse when a message is dropped.
- `err_timeout` out 1 — one-cycle pulse when WAIT times out.

## Operation
- **State machine:** COLLECT, DROP, FEED, WAIT.
- **Reset:**
  - State returns to COLLECT.
  - Length, read and write pointers, and timeout counter go to 0.
  - All outputs go to 0 except `in_ready`, which is 1.
  - Buffer contents are discarded; reset mid-FEED or mid-WAIT aborts the message with no digest pulse.
- **COLLECT:**
  - `in_ready`=1. Each accepted byte is written to `buf[len]` and `len` increments.
  - Accepted byte with `in_last`=1 → FEED. `len` includes that byte, so message length is at least 1.
  - Accepted byte that brings `len` to `DEPTH` with `in_last`=0 → DROP. `err_overflow` pulses; `len` clears.
- **DROP:**
  - `in_ready`=1 and accepted bytes are discarded.
  - Accepted byte with `in_last`=1 → COLLECT.
- **FEED:**
  - `in_ready`=0.
  - Bytes `buf[0..len-1]` are presented in order, one per cycle, with `M_valid`=1 and `counter`=`len`.
  - After the last byte → WAIT.
- **WAIT:**
  - `in_ready`=0. `hash_ready` is registered, and a rising edge (previous sample 0, current 1) is detected.
  - On a rising edge: `digest_out`←`digest_in`, `digest_valid` pulses, `len` clears → COLLECT.
  - If `TIMEOUT` cycles pass in WAIT with no rising edge: `err_timeout` pulses, `digest_out` is unchanged → COLLECT.
  - A `hash_ready` level already high on WAIT entry does not count.
- **Output values outside FEED:** `message`=0, `counter`=0, `M_valid`=0.
- **Digest hold:** `digest_out` holds its value until the next capture.
- **Arithmetic:** `len` and the pointers are log2(`DEPTH`)+1 bits wide. `counter` = {zeros, `len`}.

## Timing
- All outputs are registered.
- **FEED burst:** last byte accepted at edge E.
  - `M_valid` is high for exactly `len` consecutive cycles, starting after edge E+1.
  - `message` and `counter` are valid in those same cycles.
- **Back-to-back:** `in_ready` rises in the cycle after the edge that captures the digest or times out.
- **Error pulses:** `err_overflow` and `err_timeout` are each exactly one cycle, registered on the edge of the triggering event.
- **Simultaneous events in WAIT:** a `hash_ready` rising edge on the same edge as timeout expiry counts as success (digest captured, no `err_timeout`).
- **Input during FEED/WAIT:** host `in_valid` is ignored because `in_ready`=0.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-FEED, then release → `M_valid`=0, `in_ready`=1, `busy`=0, `digest_valid`=0, state COLLECT; the next message is fed from `buf[0]`.
- **Single byte:** send "A" (0x41) with `in_last` → one `M_valid` cycle with `message`=0x41 and `counter`=1. Model the core raising `hash_ready` 3 cycles later with `digest_in`=32'h4dd99065 → `digest_out`=32'h4dd99065 and a one-cycle `digest_valid`.
- **Multi-byte ordering:** send "ABC" → `M_valid` high for 3 consecutive cycles with `message` 0x41, 0x42, 0x43 and `counter`=3 in each; `busy`=1 throughout.
- **Overflow:** with `DEPTH`=16, send 16 bytes without `in_last` → `err_overflow` pulses and no `M_valid`. Send 3 more bytes, the last with `in_last` → back to COLLECT. A following 1-byte message is fed normally.
- **Timeout:** hold `hash_ready`=1 constantly through WAIT → no rising edge; after 64 cycles `err_timeout` pulses, `digest_out` is unchanged, `in_ready` returns to 1.
- **Simultaneous:** `hash_ready` rises on the 64th WAIT cycle → digest captured, `err_timeout` stays 0.
